// File: rtl/huff_sort_if.sv
// Handshake and result bus between the Huffman symbol counter and the sort engine.
interface huff_sort_if #(
    parameter int N = 6,
    parameter int W = 8
);
    localparam int IW = $clog2(N);
    localparam int NW = $clog2(N + 1);

    logic              start;
    logic [NW-1:0]     num;
    logic              desc;
    logic [N*W-1:0]    cnt_in;
    logic [N*IW-1:0]   order;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic [IW-1:0]     out_idx;
    logic [W-1:0]      out_cnt;

    modport master (
        output start, num, desc, cnt_in,
        input  order, busy, done, out_valid, out_idx, out_cnt
    );

    modport slave (
        input  start, num, desc, cnt_in,
        output order, busy, done, out_valid, out_idx, out_cnt
    );
endinterface

// File: rtl/huff_sort_engine.sv
// Stable selection sorter producing rank-ordered symbol indices from symbol counts.
// Optional per-rank result stream enabled by defining HUFF_SORT_STREAM_EN.
module huff_sort_engine #(
    parameter int N = 6,
    parameter int W = 8
) (
    input  logic       clk,
    input  logic       reset,
    huff_sort_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int NW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t            state_q, state_d;
    logic [NW-1:0]     num_q, num_d;
    logic              desc_q, desc_d;
    logic [N-1:0]      used_q, used_d;
    logic [IW-1:0]     i_q, i_d;
    logic [IW-1:0]     r_q, r_d;
    logic              bvld_q, bvld_d;
    logic [IW-1:0]     bidx_q, bidx_d;
    logic [W-1:0]      bcnt_q, bcnt_d;
    logic [W-1:0]      cnt_q [N];
    logic [W-1:0]      cnt_d [N];
    logic [IW-1:0]     order_q [N];
    logic [IW-1:0]     order_d [N];

    logic [NW-1:0]     num_eff;
    logic [W-1:0]      cand_cnt;
    logic              take, last_scan, last_rank;
    logic [IW-1:0]     win_idx;
    logic [W-1:0]      win_cnt;

    assign num_eff   = (bus.num > NW'(N)) ? NW'(N) : bus.num;
    assign cand_cnt  = cnt_q[i_q];
    assign last_scan = (NW'(i_q) == num_q - NW'(1));
    assign last_rank = (NW'(r_q) == num_q - NW'(1));

    // Strict compare keeps the earliest index on ties, which makes the sort stable.
    assign take = (NW'(i_q) < num_q) && !used_q[i_q] &&
                  (!bvld_q || (desc_q ? (cand_cnt > bcnt_q) : (cand_cnt < bcnt_q)));
    assign win_idx = take ? i_q : bidx_q;
    assign win_cnt = take ? cand_cnt : bcnt_q;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        desc_d  = desc_q;
        used_d  = used_q;
        i_d     = i_q;
        r_d     = r_q;
        bvld_d  = bvld_q;
        bidx_d  = bidx_q;
        bcnt_d  = bcnt_q;
        cnt_d   = cnt_q;
        order_d = order_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    num_d  = num_eff;
                    desc_d = bus.desc;
                    used_d = '0;
                    i_d    = '0;
                    r_d    = '0;
                    bvld_d = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        cnt_d[k]   = bus.cnt_in[k*W +: W];
                        order_d[k] = IW'(k);
                    end
                    state_d = (num_eff == '0) ? DONE : SORT;
                end
            end
            SORT: begin
                if (last_scan) begin
                    order_d[r_q]    = win_idx;
                    used_d[win_idx] = 1'b1;
                    r_d             = r_q + IW'(1);
                    i_d             = '0;
                    bvld_d          = 1'b0;
                    if (last_rank) state_d = DONE;
                end else begin
                    i_d    = i_q + IW'(1);
                    bvld_d = bvld_q | take;
                    bidx_d = win_idx;
                    bcnt_d = win_cnt;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            num_q   <= '0;
            desc_q  <= 1'b0;
            used_q  <= '0;
            i_q     <= '0;
            r_q     <= '0;
            bvld_q  <= 1'b0;
            for (int k = 0; k < N; k++) order_q[k] <= IW'(k);
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            desc_q  <= desc_d;
            used_q  <= used_d;
            i_q     <= i_d;
            r_q     <= r_d;
            bvld_q  <= bvld_d;
            order_q <= order_d;
        end
    end

    // Latched counts and the running best are only meaningful under control qualifiers.
    always_ff @(posedge clk) begin
        cnt_q  <= cnt_d;
        bidx_q <= bidx_d;
        bcnt_q <= bcnt_d;
    end

    for (genvar g = 0; g < N; g++) begin : g_order
        assign bus.order[g*IW +: IW] = order_q[g];
    end

    assign bus.busy = (state_q == SORT);
    assign bus.done = (state_q == DONE);

`ifdef HUFF_SORT_STREAM_EN
    logic          commit;
    logic          ov_q;
    logic [IW-1:0] oidx_q;
    logic [W-1:0]  ocnt_q;

    assign commit = (state_q == SORT) && last_scan;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ov_q   <= 1'b0;
            oidx_q <= '0;
            ocnt_q <= '0;
        end else begin
            ov_q <= commit;
            if (commit) begin
                oidx_q <= win_idx;
                ocnt_q <= win_cnt;
            end
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.out_idx   = oidx_q;
    assign bus.out_cnt   = ocnt_q;
`else
    assign bus.out_valid = 1'b0;
    assign bus.out_idx   = '0;
    assign bus.out_cnt   = '0;
`endif
endmodule
